// File: rtl/wb_decompressor.sv
// wb_decompressor
//   Unpacks a compact word-serial command stream into Wishbone master cycles.
//   A transaction is a command word, an address word and, for writes, one data
//   word per beat. Single, 4-beat and 8-beat bursts are supported. Each beat
//   is answered with a one-cycle cw_ack (slave ack) or cw_err (slave error).
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   cw_io_i  [15:0]    command / address / write-data words from the initiator
//   cw_io_o  [15:0]    last word read from the Wishbone slave
//   cw_req             initiator word strobe
//   cw_dir             bus direction from the initiator (does not affect cw_io_o)
//   cw_ack, cw_err     one-cycle beat completion / beat failure
//   wb_*               Wishbone master interface with burst-length hints
module wb_decompressor (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] cw_io_i,
    output logic [15:0] cw_io_o,
    input  logic        cw_req,
    input  logic        cw_dir,
    output logic        cw_ack,
    output logic        cw_err,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [23:0] wb_adr,
    output logic [15:0] wb_o_dat,
    input  logic [15:0] wb_i_dat,
    input  logic        wb_ack,
    input  logic        wb_err,
    output logic [1:0]  wb_sel,
    output logic        wb_4_burst,
    output logic        wb_8_burst
);

    typedef enum logic [2:0] {
        IDLE,
        ADR,
        WDATA,
        WB,
        RESP
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] beats_left;

    // cw_dir has no effect on this side of the bus; cw_io_o is always driven.
    logic       unused_dir;
    assign unused_dir = cw_dir;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cw_req) state_next = ADR;
            ADR:     state_next = cw_req ? (wb_we ? WDATA : WB) : IDLE;
            WDATA:   if (cw_req) state_next = WB;
            WB:      if (wb_ack || wb_err) state_next = RESP;
            // beats_left is forced to zero on a slave error, so this also
            // covers the abandon-burst case.
            RESP:    if (beats_left == '0) state_next = IDLE;
                     else                  state_next = wb_we ? WDATA : WB;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cw_io_o    <= '0;
            cw_ack     <= 1'b0;
            cw_err     <= 1'b0;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_we      <= 1'b0;
            wb_adr     <= '0;
            wb_o_dat   <= '0;
            wb_sel     <= '0;
            wb_4_burst <= 1'b0;
            wb_8_burst <= 1'b0;
            beats_left <= '0;
        end else begin
            cw_ack <= 1'b0;
            cw_err <= 1'b0;
            wb_stb <= (state_next == WB);

            case (state)
                IDLE: begin
                    if (cw_req) begin
                        wb_we      <= cw_io_i[15];
                        wb_8_burst <= cw_io_i[13];
                        wb_4_burst <= cw_io_i[14] & ~cw_io_i[13];
                        wb_sel     <= cw_io_i[12:11];
                        wb_adr     <= {cw_io_i[7:0], wb_adr[15:0]};
                        beats_left <= cw_io_i[13] ? 4'd8 : (cw_io_i[14] ? 4'd4 : 4'd1);
                    end
                end
                ADR: begin
                    if (cw_req) begin
                        wb_adr[15:0] <= cw_io_i;
                    end else begin
                        cw_err <= 1'b1;
                    end
                end
                WDATA: begin
                    if (cw_req) begin
                        wb_o_dat <= cw_io_i;
                    end
                end
                WB: begin
                    // Error takes priority over a simultaneous ack.
                    if (wb_err) begin
                        cw_err     <= 1'b1;
                        beats_left <= '0;
                        wb_cyc     <= 1'b0;
                    end else if (wb_ack) begin
                        cw_ack     <= 1'b1;
                        beats_left <= beats_left - 4'd1;
                        // Keep the bus owned through RESP only if more beats follow.
                        wb_cyc     <= (beats_left != 4'd1);
                        if (!wb_we) begin
                            cw_io_o <= wb_i_dat;
                        end
                    end
                end
                RESP: begin
                    if (beats_left != '0) begin
                        wb_adr <= wb_adr + 24'd1;
                    end
                end
                default: ;
            endcase

            if (state_next == WB) begin
                wb_cyc <= 1'b1;
            end
            if (state_next == IDLE) begin
                wb_4_burst <= 1'b0;
                wb_8_burst <= 1'b0;
            end
        end
    end

endmodule
